pipe_ctrl_unit: RTL and testbench

Second-generation control unit for the 5-stage RISC-V pipeline. It decodes the ID-stage instruction into a full ALU/memory/writeback control bundle and registers that bundle as the ID/EX control word. It also owns hazard sequencing:
- load-use stall with bubble insertion
- beq flush
- a parametrised multi-cycle MUL freeze, driven by a state machine and counter
It replaces a purely combinational decoder; the outputs feed PC, IF/ID, ID/EX and the EX-stage ALU.

---
 rtl/pipe_ctrl_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
//
// Control unit for the 5-stage RISC-V pipeline. It decodes the ID-stage
// instruction into an ALU/memory/writeback control bundle and registers that
// bundle as the ID/EX control word. It also sequences the pipeline hazards:
// load-use stall with bubble insertion, beq flush, and a multi-cycle MUL
// freeze driven by a small state machine and a down-counter.
//
// Parameters:
//   MUL_LAT    EX-stage cycles a mul occupies (1..15); 1 means no freeze
//   EN_HAZARD  1 enables load-use detection, 0 ties stall_o low
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   valid_i                 ID-stage instruction valid
//   opcode_i/funct3_i/
//   funct7_i                ID instruction fields
//   rs1_i, rs2_i            ID source registers
//   equal_i                 ID comparator result (rs1 == rs2)
//   ex_mem_read_i, ex_rd_i  load flag and destination of the EX instruction
//   pc_write_o              PC update enable
//   ifid_write_o            IF/ID write enable
//   branch_o, flush_o       take beq target / flush IF/ID (combinational)
//   stall_o                 load-use stall this cycle (combinational)
//   busy_o                  MUL freeze in progress
//   illegal_o               registered pulse: previous ID instruction unsupported
//   ex_*_o                  registered ID/EX control word

module pipe_ctrl_unit #(
  parameter int unsigned MUL_LAT   = 4,
  parameter bit          EN_HAZARD = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       equal_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       branch_o,
  output logic       flush_o,
  output logic       stall_o,
  output logic       busy_o,
  output logic       illegal_o,
  output logic [3:0] ex_alu_ctrl_o,
  output logic       ex_alu_src_o,
  output logic       ex_mem_read_o,
  output logic       ex_mem_write_o,
  output logic       ex_mem_to_reg_o,
  output logic       ex_reg_write_o,
  output logic       ex_mul_o
);

  // Opcodes handled by this unit
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU control encodings
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;

  // Counter preload: the freeze lasts MUL_LAT-1 cycles after the mul enters EX
  localparam logic [3:0] CNT_INIT  = 4'(MUL_LAT - 1);
  localparam bit         MUL_MULTI = (MUL_LAT > 1);

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mul;
  } ctrl_t;

  typedef enum logic {
    IDLE,
    MBUSY
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       illegal_q, illegal_d;

  ctrl_t      dec_raw;
  ctrl_t      dec_bundle;
  logic       dec_legal;
  logic       uses_rs2;
  logic       is_beq;
  logic       busy;
  logic       hazard_raw;
  logic       stall;

  // Instruction decode. Unsupported encodings fall through with dec_legal
  // low and an all-zero bundle, which doubles as the NOP bundle.
  always_comb begin
    dec_raw   = '0;
    dec_legal = 1'b0;
    uses_rs2  = 1'b0;
    is_beq    = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        // rs2 is read by every R-type encoding, legal or not
        uses_rs2 = 1'b1;
        case ({funct7_i, funct3_i})
          {7'b0000000, 3'b111}: begin dec_raw.alu_ctrl = ALU_AND; dec_legal = 1'b1; end
          {7'b0000000, 3'b110}: begin dec_raw.alu_ctrl = ALU_OR;  dec_legal = 1'b1; end
          {7'b0000000, 3'b000}: begin dec_raw.alu_ctrl = ALU_ADD; dec_legal = 1'b1; end
          {7'b0100000, 3'b000}: begin dec_raw.alu_ctrl = ALU_SUB; dec_legal = 1'b1; end
          {7'b0000001, 3'b000}: begin
            dec_raw.alu_ctrl = ALU_MUL;
            dec_raw.mul      = 1'b1;
            dec_legal        = 1'b1;
          end
          default: dec_legal = 1'b0;
        endcase
        dec_raw.reg_write = dec_legal;
      end
      OP_IMM: begin
        if (funct3_i == 3'b000) begin
          dec_raw.alu_ctrl = ALU_ADD;
          dec_legal        = 1'b1;
        end else if (funct3_i == 3'b101 && funct7_i == 7'b0100000) begin
          dec_raw.alu_ctrl = ALU_SRA;
          dec_legal        = 1'b1;
        end
        dec_raw.alu_src   = dec_legal;
        dec_raw.reg_write = dec_legal;
      end
      OP_LOAD: begin
        if (funct3_i == 3'b010) begin
          dec_raw.alu_ctrl   = ALU_ADD;
          dec_raw.alu_src    = 1'b1;
          dec_raw.mem_read   = 1'b1;
          dec_raw.mem_to_reg = 1'b1;
          dec_raw.reg_write  = 1'b1;
          dec_legal          = 1'b1;
        end
      end
      OP_STORE: begin
        uses_rs2 = 1'b1;
        if (funct3_i == 3'b010) begin
          dec_raw.alu_ctrl  = ALU_ADD;
          dec_raw.alu_src   = 1'b1;
          dec_raw.mem_write = 1'b1;
          dec_legal         = 1'b1;
        end
      end
      OP_BRANCH: begin
        uses_rs2 = 1'b1;
        if (funct3_i == 3'b000) begin
          dec_raw.alu_ctrl = ALU_SUB;
          is_beq           = 1'b1;
          dec_legal        = 1'b1;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Only a valid, supported instruction produces a non-NOP bundle
  always_comb begin
    dec_bundle = '0;
    if (valid_i && dec_legal) begin
      dec_bundle = dec_raw;
    end
  end

  // Hazard detection. The MUL freeze masks the stall so the frozen ID
  // instruction is re-evaluated once the freeze ends.
  always_comb begin
    busy       = (state_q == MBUSY);
    hazard_raw = ex_mem_read_i && (ex_rd_i != 5'd0) && valid_i &&
                 ((ex_rd_i == rs1_i) || (uses_rs2 && (ex_rd_i == rs2_i)));
    stall      = EN_HAZARD && hazard_raw && !busy;
  end

  // Pipeline control outputs
  always_comb begin
    stall_o      = stall;
    busy_o       = busy;
    pc_write_o   = !stall && !busy;
    ifid_write_o = !stall && !busy;
    branch_o     = is_beq && equal_i && valid_i && !stall && !busy;
    flush_o      = is_beq && equal_i && valid_i && !stall && !busy;
  end

  // Next-state logic for the MUL FSM, the counter and the ID/EX word.
  // MBUSY holds the mul bundle; in IDLE a stall inserts a bubble, otherwise
  // the decoded bundle is loaded. illegal pulses only for an instruction
  // that actually advances into EX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (stall) begin
          ctrl_d = '0;
        end else begin
          ctrl_d    = dec_bundle;
          illegal_d = valid_i && !dec_legal;
          if (dec_bundle.mul && MUL_MULTI) begin
            state_d = MBUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      MBUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers; reset discards any in-flight mul and clears the word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    illegal_o       = illegal_q;
    ex_alu_ctrl_o   = ctrl_q.alu_ctrl;
    ex_alu_src_o    = ctrl_q.alu_src;
    ex_mem_read_o   = ctrl_q.mem_read;
    ex_mem_write_o  = ctrl_q.mem_write;
    ex_mem_to_reg_o = ctrl_q.mem_to_reg;
    ex_reg_write_o  = ctrl_q.reg_write;
    ex_mul_o        = ctrl_q.mul;
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit. A reference decoder produces the expected
// ID/EX bundle for each driven instruction; expectations are queued when the
// stimulus is applied and compared one clock later. A second instance with
// MUL_LAT=1 shares the stimulus and must never freeze.

module tb_pipe_ctrl_unit;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic [4:0] rs1_i;
  logic [4:0] rs2_i;
  logic       equal_i;
  logic       ex_mem_read_i;
  logic [4:0] ex_rd_i;

  logic       pc_write_o, ifid_write_o, branch_o, flush_o, stall_o, busy_o, illegal_o;
  logic [3:0] ex_alu_ctrl_o;
  logic       ex_alu_src_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_reg_write_o, ex_mul_o;

  logic       pc_write2, ifid_write2, branch2, flush2, stall2, busy2, illegal2;
  logic [3:0] alu_ctrl2;
  logic       alu_src2, mem_read2, mem_write2, mem_to_reg2, reg_write2, mul2;

  logic [10:0] got_bundle;
  logic [10:0] sb_q[$];
  logic        busy2_seen = 1'b0;
  int          tests_run = 0;
  int          tests_failed = 0;

  localparam logic [10:0] NOP = 11'd0;

  pipe_ctrl_unit #(.MUL_LAT(4), .EN_HAZARD(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .opcode_i(opcode_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .equal_i(equal_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .branch_o(branch_o),
    .flush_o(flush_o), .stall_o(stall_o), .busy_o(busy_o), .illegal_o(illegal_o),
    .ex_alu_ctrl_o(ex_alu_ctrl_o), .ex_alu_src_o(ex_alu_src_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_mul_o(ex_mul_o)
  );

  pipe_ctrl_unit #(.MUL_LAT(1), .EN_HAZARD(1'b1)) dut_lat1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .opcode_i(opcode_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .equal_i(equal_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
    .pc_write_o(pc_write2), .ifid_write_o(ifid_write2), .branch_o(branch2),
    .flush_o(flush2), .stall_o(stall2), .busy_o(busy2), .illegal_o(illegal2),
    .ex_alu_ctrl_o(alu_ctrl2), .ex_alu_src_o(alu_src2),
    .ex_mem_read_o(mem_read2), .ex_mem_write_o(mem_write2),
    .ex_mem_to_reg_o(mem_to_reg2), .ex_reg_write_o(reg_write2),
    .ex_mul_o(mul2)
  );

  // Free-running clock, period 10
  always #5 clk_i = ~clk_i;

  // Sticky flag: the MUL_LAT=1 instance must never raise busy
  always @(negedge clk_i) begin
    if (busy2 === 1'b1) busy2_seen <= 1'b1;
  end

  assign got_bundle = {illegal_o, ex_alu_ctrl_o, ex_alu_src_o, ex_mem_read_o,
                       ex_mem_write_o, ex_mem_to_reg_o, ex_reg_write_o, ex_mul_o};

  // Reference decoder: {illegal, alu_ctrl, alu_src, mem_read, mem_write,
  // mem_to_reg, reg_write, mul}
  function automatic logic [10:0] refDecode(input logic v, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7);
    logic [3:0] alu;
    logic src, mr, mw, m2r, rw, mul, ill;
    alu = 4'd0; src = 0; mr = 0; mw = 0; m2r = 0; rw = 0; mul = 0; ill = 0;
    if (v) begin
      if      (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) begin alu = 4'b0000; rw = 1; end
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) begin alu = 4'b0001; rw = 1; end
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin alu = 4'b0010; rw = 1; end
      else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin alu = 4'b0110; rw = 1; end
      else if (op == 7'h33 && f7 == 7'h01 && f3 == 3'd0) begin alu = 4'b0011; rw = 1; mul = 1; end
      else if (op == 7'h13 && f3 == 3'd0) begin alu = 4'b0010; src = 1; rw = 1; end
      else if (op == 7'h13 && f3 == 3'd5 && f7 == 7'h20) begin alu = 4'b0111; src = 1; rw = 1; end
      else if (op == 7'h03 && f3 == 3'd2) begin alu = 4'b0010; src = 1; mr = 1; m2r = 1; rw = 1; end
      else if (op == 7'h23 && f3 == 3'd2) begin alu = 4'b0010; src = 1; mw = 1; end
      else if (op == 7'h63 && f3 == 3'd0) begin alu = 4'b0110; end
      else ill = 1;
    end
    return {ill, alu, src, mr, mw, m2r, rw, mul};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                               input logic eq, input logic exmr, input logic [4:0] exrd);
    valid_i = v; opcode_i = op; funct3_i = f3; funct7_i = f7;
    rs1_i = r1; rs2_i = r2; equal_i = eq; ex_mem_read_i = exmr; ex_rd_i = exrd;
    #1;
  endtask

  task automatic expectBundle(input logic [10:0] b);
    sb_q.push_back(b);
  endtask

  // Advance one clock and compare the registered bundle with the queue head
  task automatic tick(input string tag);
    logic [10:0] exp;
    @(posedge clk_i);
    #1;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      checkOutput(tag, got_bundle, exp);
    end
  endtask

  // Decode stimulus table: opcode, funct3, funct7
  logic [6:0] tbl_op [9] = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h03, 7'h23, 7'h63};
  logic [2:0] tbl_f3 [9] = '{3'd0,  3'd0,  3'd7,  3'd6,  3'd0,  3'd5,  3'd2,  3'd2,  3'd0};
  logic [6:0] tbl_f7 [9] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
  string      tbl_nm [9] = '{"add", "sub", "and", "or", "addi", "srai", "lw", "sw", "beq"};

  initial begin
    // Reset
    rst_i = 1'b1;
    applyStimulus(0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 0, 0, 5'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    checkOutput("rst_bundle", got_bundle, NOP);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_pc_write", pc_write_o, 1);
    checkOutput("rst_ifid_write", ifid_write_o, 1);

    // Decode of every supported instruction
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, tbl_op[i], tbl_f3[i], tbl_f7[i], 5'd1, 5'd2, 0, 0, 5'd0);
      checkOutput({"nobranch_", tbl_nm[i]}, branch_o, 0);
      expectBundle(refDecode(1, tbl_op[i], tbl_f3[i], tbl_f7[i]));
      tick({"dec_", tbl_nm[i]});
    end

    // Load-use on rs2 of an add -> stall and bubble
    applyStimulus(1, 7'h33, 3'd0, 7'h00, 5'd1, 5'd5, 0, 1, 5'd5);
    checkOutput("lu_stall", stall_o, 1);
    checkOutput("lu_pc_write", pc_write_o, 0);
    checkOutput("lu_ifid_write", ifid_write_o, 0);
    expectBundle(NOP);
    tick("lu_bubble");
    // Same hazard shape with ex_rd = x0 -> no stall
    applyStimulus(1, 7'h33, 3'd0, 7'h00, 5'd0, 5'd0, 0, 1, 5'd0);
    checkOutput("lu_x0_stall", stall_o, 0);
    checkOutput("lu_x0_pc_write", pc_write_o, 1);
    expectBundle(refDecode(1, 7'h33, 3'd0, 7'h00));
    tick("lu_x0_add");
    // addi does not read rs2, so a matching rs2 field is not a hazard
    applyStimulus(1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd5, 0, 1, 5'd5);
    checkOutput("lu_addi_stall", stall_o, 0);
    expectBundle(refDecode(1, 7'h13, 3'd0, 7'h00));
    tick("lu_addi");

    // Branch taken, then the same beq under a load-use stall
    applyStimulus(1, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 1, 0, 5'd0);
    checkOutput("br_branch", branch_o, 1);
    checkOutput("br_flush", flush_o, 1);
    expectBundle(refDecode(1, 7'h63, 3'd0, 7'h00));
    tick("br_bundle");
    applyStimulus(1, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 1, 1, 5'd1);
    checkOutput("br_stall", stall_o, 1);
    checkOutput("br_stall_branch", branch_o, 0);
    checkOutput("br_stall_flush", flush_o, 0);
    expectBundle(NOP);
    tick("br_bubble");

    // Illegal encoding, valid then invalid
    applyStimulus(1, 7'h7F, 3'd0, 7'h00, 5'd1, 5'd2, 0, 0, 5'd0);
    expectBundle(11'b100_0000_0000);
    tick("ill_valid");
    applyStimulus(0, 7'h7F, 3'd0, 7'h00, 5'd1, 5'd2, 0, 0, 5'd0);
    expectBundle(NOP);
    tick("ill_invalid");

    // MUL freeze with MUL_LAT=4, followed by an add
    applyStimulus(1, 7'h33, 3'd0, 7'h01, 5'd3, 5'd4, 0, 0, 5'd0);
    expectBundle(refDecode(1, 7'h33, 3'd0, 7'h01));
    tick("mul_c1");
    checkOutput("mul_busy_c1", busy_o, 1);
    checkOutput("mul_pc_write_c1", pc_write_o, 0);
    applyStimulus(1, 7'h33, 3'd0, 7'h00, 5'd6, 5'd7, 0, 0, 5'd0);
    for (int c = 2; c <= 3; c++) begin
      expectBundle(refDecode(1, 7'h33, 3'd0, 7'h01));
      tick($sformatf("mul_hold_c%0d", c));
      checkOutput($sformatf("mul_busy_c%0d", c), busy_o, 1);
      checkOutput($sformatf("mul_ifid_c%0d", c), ifid_write_o, 0);
    end
    expectBundle(refDecode(1, 7'h33, 3'd0, 7'h01));
    tick("mul_hold_c4");
    checkOutput("mul_busy_c4", busy_o, 0);
    checkOutput("mul_pc_write_c4", pc_write_o, 1);
    expectBundle(refDecode(1, 7'h33, 3'd0, 7'h00));
    tick("mul_add_c5");
    checkOutput("mul_busy_c5", busy_o, 0);

    // Reset on the second MBUSY cycle; beq/hazard masked while frozen
    applyStimulus(1, 7'h33, 3'd0, 7'h01, 5'd3, 5'd4, 0, 0, 5'd0);
    expectBundle(refDecode(1, 7'h33, 3'd0, 7'h01));
    tick("rm_c1");
    applyStimulus(1, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 1, 1, 5'd1);
    checkOutput("rm_busy_c1", busy_o, 1);
    checkOutput("rm_branch_masked", branch_o, 0);
    checkOutput("rm_flush_masked", flush_o, 0);
    checkOutput("rm_stall_masked", stall_o, 0);
    expectBundle(refDecode(1, 7'h33, 3'd0, 7'h01));
    tick("rm_c2");
    rst_i = 1'b1;
    expectBundle(NOP);
    tick("rm_cleared");
    checkOutput("rm_busy_after_rst", busy_o, 0);
    rst_i = 1'b0;
    applyStimulus(0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 0, 0, 5'd0);
    checkOutput("rm_pc_write", pc_write_o, 1);
    @(posedge clk_i);
    #1;

    // The MUL_LAT=1 instance saw both muls and must never have frozen
    checkOutput("lat1_busy_never", busy2_seen, 0);
    checkOutput("queue_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
